// File: rtl/amp_det_pkg.sv
// amp_det_pkg: shared defaults, widths and detector state encoding.
// Ports: none. Holds NP/MA/FS defaults, divider widths, the UP/DN encoding
// and a quotient-to-8-bit saturation helper.
package amp_det_pkg;

  localparam int NP_DEF = 100;                  // triangle points per period
  localparam int MA_DEF = 4000 / (NP_DEF / 2);  // scale so full scale is 4000
  localparam int FS_DEF = (NP_DEF / 2) * MA_DEF;

  localparam int DW       = 12;  // sample / amplitude width
  localparam int PW       = 8;   // period and gain width
  localparam int DIV_W    = 20;  // divider dividend / quotient width
  localparam int DSR_W    = 12;  // divider divisor width
  localparam int UNITY_SH = 7;   // unity gain M=128 expressed as a shift

  typedef enum logic {
    ST_UP = 1'b0,
    ST_DN = 1'b1
  } det_state_t;

  // Clamp a wide quotient to the 8-bit gain range.
  function automatic logic [PW-1:0] sat8(input logic [DIV_W-1:0] q);
    if (q > DIV_W'(255)) return 8'hFF;
    return q[PW-1:0];
  endfunction

endpackage

// File: rtl/amp_det_if.sv
// amp_det_if: sample stream in, detector results out.
// master drives ce/din and observes results; slave is the detector side.
// Signals: ce, din, peak, trough, amp, period, m_est, m_valid, busy, ovr, lock.
interface amp_det_if;
  import amp_det_pkg::*;

  logic          ce;
  logic [DW-1:0] din;
  logic [DW-1:0] peak;
  logic [DW-1:0] trough;
  logic [DW-1:0] amp;
  logic [PW-1:0] period;
  logic [PW-1:0] m_est;
  logic          m_valid;
  logic          busy;
  logic          ovr;
  logic          lock;

  modport master (
    output ce, din,
    input  peak, trough, amp, period, m_est, m_valid, busy, ovr, lock
  );

  modport slave (
    input  ce, din,
    output peak, trough, amp, period, m_est, m_valid, busy, ovr, lock
  );

endinterface

// File: rtl/amp_det_udiv_seq.sv
// udiv_seq: restoring unsigned divider, one quotient bit per clk.
// Ports: clk, rst, start (accepted when idle), dividend, divisor -> busy,
// done (one-clk pulse, quot final), quot. First bit is resolved on the start clk.
module udiv_seq #(
  parameter int DND_W = 20,
  parameter int DSR_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DND_W-1:0] dividend,
  input  logic [DSR_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DND_W-1:0] quot
);

  localparam int CW = $clog2(DND_W + 1);

  logic [DSR_W-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             ld;
  logic [DSR_W-1:0] rem_in;
  logic [DND_W-1:0] q_in;
  logic [DSR_W:0]   trial;
  logic [DSR_W-1:0] rem_nx;
  logic [DND_W-1:0] q_nx;

  assign ld = start && !busy;

  // One restoring step. On a load the step runs on the fresh dividend so
  // the whole division fits in DND_W clocks starting at the start clk.
  always_comb begin
    rem_in = ld ? '0 : rem_q;
    q_in   = ld ? dividend : quot;
    trial  = {rem_in, q_in[DND_W-1]};
    if (trial >= {1'b0, divisor}) begin
      rem_nx = DSR_W'(trial - {1'b0, divisor});
      q_nx   = {q_in[DND_W-2:0], 1'b1};
    end else begin
      rem_nx = trial[DSR_W-1:0];
      q_nx   = {q_in[DND_W-2:0], 1'b0};
    end
  end

  // busy covers the steps plus the done clk, so a consumer sees busy fall
  // on the same edge it registers the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quot  <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ld) begin
        rem_q <= rem_nx;
        quot  <= q_nx;
        cnt_q <= CW'(DND_W - 1);
        busy  <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end else if (busy && cnt_q != '0) begin
        rem_q <= rem_nx;
        quot  <= q_nx;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/amp_det.sv
// amp_det: peak/trough/period detector on a scaled triangle, gain recovery.
// Ports: clk, rst (async, active high), bus (amp_det_if.slave).
// m_est = round(peak*128/FS), valid 21 clks after the detecting ce clk.
module amp_det
  import amp_det_pkg::*;
#(
  parameter int NP = NP_DEF,
  parameter int MA = 4000 / (NP / 2)
) (
  input logic        clk,
  input logic        rst,
  amp_det_if.slave   bus
);

  localparam int               FS      = (NP / 2) * MA;
  localparam logic [DIV_W-1:0] HALF_FS = DIV_W'(FS / 2);
  localparam logic [DSR_W-1:0] FS_DIV  = DSR_W'(FS);

  det_state_t    state_q, state_d;
  logic          pk_det, tr_det;
  logic [DW-1:0] prev_q, peak_q, trough_q, amp_q;
  logic [PW-1:0] cnt_q, period_q, m_est_q;
  logic          m_valid_q, ovr_q, lock_q, seen_pk_q, start_q;

  logic             div_busy, div_done, div_gate;
  logic [DIV_W-1:0] div_quot, dividend;

  // start_q covers the clk between detection and the divider going busy.
  assign div_gate = div_busy || start_q;
  // Rounded dividend, taken from the peak register updated at detection.
  assign dividend = (DIV_W'(peak_q) << UNITY_SH) + HALF_FS;

  always_comb begin
    state_d = state_q;
    pk_det  = 1'b0;
    tr_det  = 1'b0;
    if (bus.ce) begin
      case (state_q)
        ST_UP: if (bus.din < prev_q) begin
          pk_det  = 1'b1;
          state_d = ST_DN;
        end
        ST_DN: if (bus.din > prev_q) begin
          tr_det  = 1'b1;
          state_d = ST_UP;
        end
        default: state_d = ST_UP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_UP;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      peak_q    <= '0;
      trough_q  <= '0;
      amp_q     <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      m_est_q   <= '0;
      m_valid_q <= 1'b0;
      ovr_q     <= 1'b0;
      lock_q    <= 1'b0;
      seen_pk_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      amp_q     <= (peak_q >= trough_q) ? peak_q - trough_q : '0;
      start_q   <= pk_det && !div_gate;
      ovr_q     <= pk_det && div_gate;
      m_valid_q <= div_done;
      if (div_done) m_est_q <= sat8(div_quot);
      if (bus.ce) begin
        prev_q <= bus.din;
        if (pk_det) begin
          peak_q    <= prev_q;
          period_q  <= cnt_q;
          cnt_q     <= 8'd1;
          seen_pk_q <= 1'b1;
          if (seen_pk_q) lock_q <= 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_q <= cnt_q + 8'd1;
        end
        if (tr_det) trough_q <= prev_q;
      end
    end
  end

  udiv_seq #(
    .DND_W(DIV_W),
    .DSR_W(DSR_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (start_q),
    .dividend(dividend),
    .divisor (FS_DIV),
    .busy    (div_busy),
    .done    (div_done),
    .quot    (div_quot)
  );

  assign bus.peak    = peak_q;
  assign bus.trough  = trough_q;
  assign bus.amp     = amp_q;
  assign bus.period  = period_q;
  assign bus.m_est   = m_est_q;
  assign bus.m_valid = m_valid_q;
  assign bus.busy    = div_busy;
  assign bus.ovr     = ovr_q;
  assign bus.lock    = lock_q;

endmodule

// File: tb/tb_amp_det.sv
// tb_amp_det: scenario tasks against a sample-level reference model.
// Ports: none (drives amp_det through amp_det_if).
// Division timing is modelled as a 21-clk window from the detecting clk.
module tb_amp_det;
  import amp_det_pkg::*;

  localparam int FS = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  amp_det_if bus();

  amp_det #(.NP(100), .MA(80)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state.
  bit r_rising;
  int r_prev, r_peak, r_trough, r_amp, r_period, r_cnt, r_mest;
  int r_npk, r_novr, r_nmv, r_div_start, r_div_val;
  bit e_busy, e_mvalid, e_ovr, r_lock;

  task automatic model_reset();
    r_rising = 1; r_prev = 0; r_peak = 0; r_trough = 0; r_amp = 0;
    r_period = 0; r_cnt = 0; r_mest = 0; r_npk = 0; r_novr = 0; r_nmv = 0;
    r_div_start = -1000; r_div_val = 0;
    e_busy = 0; e_mvalid = 0; e_ovr = 0; r_lock = 0;
  endtask

  // Advance the model by one clock edge with the given ce/din.
  task automatic model_edge(input bit c, input int d);
    int amp_n;
    bit pk, tr;
    amp_n = (r_peak >= r_trough) ? r_peak - r_trough : 0;
    e_ovr = 0;
    pk = 0;
    tr = 0;
    if (c) begin
      pk = r_rising && (d < r_prev);
      tr = !r_rising && (d > r_prev);
      if (pk) begin
        r_peak = r_prev;
        r_rising = 0;
        r_period = r_cnt;
        r_cnt = 1;
        r_npk++;
        if (cyc - r_div_start <= 21) begin
          e_ovr = 1;
          r_novr++;
        end else begin
          r_div_start = cyc;
          r_div_val = (r_peak * 128 + FS / 2) / FS;
          if (r_div_val > 255) r_div_val = 255;
        end
      end else begin
        r_cnt = (r_cnt < 255) ? r_cnt + 1 : 255;
      end
      if (tr) begin
        r_trough = r_prev;
        r_rising = 1;
      end
      r_prev = d;
    end
    r_amp = amp_n;
    e_busy = (cyc >= r_div_start + 1) && (cyc <= r_div_start + 20);
    e_mvalid = (cyc == r_div_start + 21);
    if (e_mvalid) begin
      r_mest = r_div_val;
      r_nmv++;
    end
    r_lock = (r_npk >= 2);
  endtask

  task automatic tick(input bit c, input int d);
    @(negedge clk);
    bus.ce = c;
    bus.din = 12'(d);
    @(posedge clk);
    cyc++;
    model_edge(c, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ce = 1'b0;
    bus.din = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic int tri_val(input int idx, input int m);
    int t;
    t = idx % 102;
    if (t > 50) t = 101 - t;
    return t * 80 * m / 128;
  endfunction

  task automatic test_reset();
    logic [11:0] obs [9];
    string nm [9] = '{"peak", "trough", "amp", "period", "m_est", "m_valid", "busy", "ovr", "lock"};
    rst = 1'b1;
    bus.ce = 1'b0;
    bus.din = '0;
    #3;
    obs = '{bus.peak, bus.trough, bus.amp, 12'(bus.period), 12'(bus.m_est),
            12'(bus.m_valid), 12'(bus.busy), 12'(bus.ovr), 12'(bus.lock)};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs[i] !== 12'd0) begin
        failures++;
        $display("FAIL reset_%s got=%0h exp=0", nm[i], obs[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_triangle(input int m);
    int phase, n, pk_full;
    bit c;
    do_reset();
    phase = $urandom_range(0, 101);
    n = 102 * 4 * 3 + 200;
    for (int i = 0; i < n; i++) begin
      c = (i % 4 == 0) && (i < n - 40);
      tick(c, c ? tri_val(phase + i / 4, m) : int'($urandom_range(0, 4095)));
      checks++; if (bus.peak !== 12'(r_peak)) begin failures++; $display("FAIL tri%0d_peak cyc=%0d got=%0d exp=%0d", m, cyc, bus.peak, r_peak); end
      checks++; if (bus.trough !== 12'(r_trough)) begin failures++; $display("FAIL tri%0d_trough cyc=%0d got=%0d exp=%0d", m, cyc, bus.trough, r_trough); end
      checks++; if (bus.amp !== 12'(r_amp)) begin failures++; $display("FAIL tri%0d_amp cyc=%0d got=%0d exp=%0d", m, cyc, bus.amp, r_amp); end
      checks++; if (bus.period !== 8'(r_period)) begin failures++; $display("FAIL tri%0d_period cyc=%0d got=%0d exp=%0d", m, cyc, bus.period, r_period); end
      checks++; if (bus.m_est !== 8'(r_mest)) begin failures++; $display("FAIL tri%0d_m_est cyc=%0d got=%0d exp=%0d", m, cyc, bus.m_est, r_mest); end
      checks++; if (bus.m_valid !== e_mvalid) begin failures++; $display("FAIL tri%0d_m_valid cyc=%0d got=%b exp=%b", m, cyc, bus.m_valid, e_mvalid); end
      checks++; if (bus.busy !== e_busy) begin failures++; $display("FAIL tri%0d_busy cyc=%0d got=%b exp=%b", m, cyc, bus.busy, e_busy); end
      checks++; if (bus.ovr !== e_ovr) begin failures++; $display("FAIL tri%0d_ovr cyc=%0d got=%b exp=%b", m, cyc, bus.ovr, e_ovr); end
      checks++; if (bus.lock !== r_lock) begin failures++; $display("FAIL tri%0d_lock cyc=%0d got=%b exp=%b", m, cyc, bus.lock, r_lock); end
    end
    pk_full = 4000 * m / 128;
    checks++; if (bus.peak !== 12'(pk_full)) begin failures++; $display("FAIL tri%0d_final_peak got=%0d exp=%0d", m, bus.peak, pk_full); end
    checks++; if (bus.trough !== 12'd0) begin failures++; $display("FAIL tri%0d_final_trough got=%0d exp=0", m, bus.trough); end
    checks++; if (bus.amp !== 12'(pk_full)) begin failures++; $display("FAIL tri%0d_final_amp got=%0d exp=%0d", m, bus.amp, pk_full); end
    checks++; if (bus.period !== 8'd102) begin failures++; $display("FAIL tri%0d_final_period got=%0d exp=102", m, bus.period); end
    checks++; if (bus.m_est !== 8'(m)) begin failures++; $display("FAIL tri%0d_final_m_est got=%0d exp=%0d", m, bus.m_est, m); end
    checks++; if (bus.lock !== 1'b1) begin failures++; $display("FAIL tri%0d_final_lock got=%b exp=1", m, bus.lock); end
  endtask

  task automatic test_flat_top();
    int vals [8] = '{3996, 3997, 3998, 3999, 4000, 4000, 3999, 3998};
    int mv, ov;
    mv = 0;
    ov = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, vals[i]);
      mv += int'(bus.m_valid);
      ov += int'(bus.ovr);
      if (i == 5) begin
        checks++; if (bus.peak !== 12'd0) begin failures++; $display("FAIL flat_no_early_peak got=%0d exp=0", bus.peak); end
      end
      if (i == 6) begin
        checks++; if (bus.peak !== 12'd4000) begin failures++; $display("FAIL flat_peak got=%0d exp=4000", bus.peak); end
        checks++; if (bus.period !== 8'd6) begin failures++; $display("FAIL flat_period got=%0d exp=6", bus.period); end
      end
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 0);
      mv += int'(bus.m_valid);
      ov += int'(bus.ovr);
    end
    checks++; if (mv != 1) begin failures++; $display("FAIL flat_m_valid_count got=%0d exp=1", mv); end
    checks++; if (ov != 0) begin failures++; $display("FAIL flat_ovr_count got=%0d exp=0", ov); end
    checks++; if (bus.m_est !== 8'd128) begin failures++; $display("FAIL flat_m_est got=%0d exp=128", bus.m_est); end
  endtask

  task automatic test_sawtooth();
    int saw [4] = '{0, 100, 200, 100};
    int mv, ov;
    mv = 0;
    ov = 0;
    do_reset();
    for (int i = 0; i < 78; i++) begin
      tick(i < 48, (i < 48) ? saw[i % 4] : 0);
      mv += int'(bus.m_valid);
      ov += int'(bus.ovr);
    end
    checks++; if (bus.peak !== 12'd200) begin failures++; $display("FAIL saw_peak got=%0d exp=200", bus.peak); end
    checks++; if (bus.m_est !== 8'd6) begin failures++; $display("FAIL saw_m_est got=%0d exp=6", bus.m_est); end
    checks++; if (ov != r_novr) begin failures++; $display("FAIL saw_ovr_count got=%0d exp=%0d", ov, r_novr); end
    checks++; if (ov == 0) begin failures++; $display("FAIL saw_ovr_seen got=%0d exp=nonzero", ov); end
    checks++; if (mv != r_nmv) begin failures++; $display("FAIL saw_m_valid_count got=%0d exp=%0d", mv, r_nmv); end
  endtask

  task automatic test_const();
    int mv;
    mv = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick(i % 2 == 0, 1234);
      mv += int'(bus.m_valid);
    end
    checks++; if (bus.period !== 8'd0) begin failures++; $display("FAIL const_period got=%0d exp=0", bus.period); end
    checks++; if (bus.lock !== 1'b0) begin failures++; $display("FAIL const_lock got=%b exp=0", bus.lock); end
    checks++; if (bus.peak !== 12'd0) begin failures++; $display("FAIL const_peak got=%0d exp=0", bus.peak); end
    checks++; if (mv != 0) begin failures++; $display("FAIL const_m_valid_count got=%0d exp=0", mv); end
    tick(1'b1, 0);
    checks++; if (bus.period !== 8'd255) begin failures++; $display("FAIL const_sat_period got=%0d exp=255", bus.period); end
    checks++; if (bus.peak !== 12'd1234) begin failures++; $display("FAIL const_drop_peak got=%0d exp=1234", bus.peak); end
  endtask

  task automatic test_reset_mid_div();
    logic [11:0] obs [9];
    string nm [9] = '{"peak", "trough", "amp", "period", "m_est", "m_valid", "busy", "ovr", "lock"};
    int i, started;
    do_reset();
    i = 0;
    started = 0;
    while (i < 600 && !started) begin
      tick(i % 4 == 0, (i % 4 == 0) ? tri_val(40 + i / 4, 128) : 0);
      started = int'(e_busy);
      i++;
    end
    checks++; if (!started) begin failures++; $display("FAIL mid_div_start got=none exp=start within 600 clks"); end
    for (int k = 0; k < 9; k++) begin
      tick((i % 4) == 0, ((i % 4) == 0) ? tri_val(40 + i / 4, 128) : 0);
      i++;
    end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_div_busy_before got=%b exp=1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    obs = '{bus.peak, bus.trough, bus.amp, 12'(bus.period), 12'(bus.m_est),
            12'(bus.m_valid), 12'(bus.busy), 12'(bus.ovr), 12'(bus.lock)};
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (obs[k] !== 12'd0) begin
        failures++;
        $display("FAIL mid_rst_%s got=%0h exp=0", nm[k], obs[k]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 236 * 4; k++) begin
      tick(k % 4 == 0, (k % 4 == 0) ? tri_val(k / 4, 128) : 0);
      checks++; if (bus.m_valid !== e_mvalid) begin failures++; $display("FAIL mid_m_valid cyc=%0d got=%b exp=%b", cyc, bus.m_valid, e_mvalid); end
      checks++; if (bus.lock !== r_lock) begin failures++; $display("FAIL mid_lock cyc=%0d got=%b exp=%b", cyc, bus.lock, r_lock); end
    end
    checks++; if (bus.lock !== 1'b1) begin failures++; $display("FAIL mid_relock got=%b exp=1", bus.lock); end
  endtask

  task automatic test_random();
    int val;
    bit c;
    do_reset();
    val = 2000;
    for (int i = 0; i < 1500; i++) begin
      c = ($urandom_range(0, 2) == 0);
      if (c) begin
        val += int'($urandom_range(0, 6)) - 3;
        if (val < 0) val = 0;
        if (val > 4095) val = 4095;
      end
      tick(c, c ? val : int'($urandom_range(0, 4095)));
      checks++; if (bus.peak !== 12'(r_peak)) begin failures++; $display("FAIL rnd_peak cyc=%0d got=%0d exp=%0d", cyc, bus.peak, r_peak); end
      checks++; if (bus.trough !== 12'(r_trough)) begin failures++; $display("FAIL rnd_trough cyc=%0d got=%0d exp=%0d", cyc, bus.trough, r_trough); end
      checks++; if (bus.amp !== 12'(r_amp)) begin failures++; $display("FAIL rnd_amp cyc=%0d got=%0d exp=%0d", cyc, bus.amp, r_amp); end
      checks++; if (bus.period !== 8'(r_period)) begin failures++; $display("FAIL rnd_period cyc=%0d got=%0d exp=%0d", cyc, bus.period, r_period); end
      checks++; if (bus.m_est !== 8'(r_mest)) begin failures++; $display("FAIL rnd_m_est cyc=%0d got=%0d exp=%0d", cyc, bus.m_est, r_mest); end
      checks++; if (bus.m_valid !== e_mvalid) begin failures++; $display("FAIL rnd_m_valid cyc=%0d got=%b exp=%b", cyc, bus.m_valid, e_mvalid); end
      checks++; if (bus.busy !== e_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, e_busy); end
      checks++; if (bus.ovr !== e_ovr) begin failures++; $display("FAIL rnd_ovr cyc=%0d got=%b exp=%b", cyc, bus.ovr, e_ovr); end
      checks++; if (bus.lock !== r_lock) begin failures++; $display("FAIL rnd_lock cyc=%0d got=%b exp=%b", cyc, bus.lock, r_lock); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_triangle(128);
    test_triangle(64);
    test_flat_top();
    test_sawtooth();
    test_const();
    test_reset_mid_div();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
